// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_ctrl
// Brief    : 4-digit common-anode seven-segment scan controller with guard
//            blanking; optional leading-zero blanking via SSD_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 16,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  output logic [3:0]  ssd_in,
  output logic [3:0]  ssd_ctl,
  output logic        frame_start
);

  // One extra bit so GUARD = 0 with SCAN_DIV = 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0]   c_show_end = (CNT_W+1)'(SCAN_DIV - GUARD);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shd;

  logic             w_load;
  logic             w_show;
  logic [15:0]      w_snap;
  logic [3:0]       w_code;
  logic             w_lz;

  assign w_load = (r_cnt == '0) && (r_idx == 2'd0);
  assign w_show = ({1'b0, r_cnt} < c_show_end);
  // Bypass so the first digit-0 cycle already shows the new snapshot.
  assign w_snap = w_load ? digits : r_shd;
  assign w_code = w_snap[{r_idx, 2'b00} +: 4];

`ifdef SSD_LZB_EN
  always_comb begin
    w_lz = 1'b0;
    case (r_idx)
      2'd3:    w_lz = (w_snap[15:12] == 4'h0);
      2'd2:    w_lz = (w_snap[15:8]  == 8'h00);
      2'd1:    w_lz = (w_snap[15:4]  == 12'h000);
      default: w_lz = 1'b0;
    endcase
  end
`else
  assign w_lz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      r_shd <= 16'h0000;
    end else begin
      if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) begin
        r_shd <= digits;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssd_in      <= 4'hF;
      ssd_ctl     <= 4'b1111;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_load;
      if (w_show) begin
        ssd_ctl <= ~(4'b0001 << r_idx);
        ssd_in  <= w_lz ? 4'hF : w_code;
      end else begin
        ssd_ctl <= 4'b1111;
        ssd_in  <= 4'hF;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_ctrl
// Brief    : Self-checking bench for ssd_scan_ctrl (SCAN_DIV=8/GUARD=2 and
//            SCAN_DIV=4/GUARD=0 instances against a cycle-count model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h1234;

  logic [3:0]  in8, ctl8, in4, ctl4;
  logic        fs8, fs4;

  int checks = 0;
  int errors = 0;

`ifdef SSD_LZB_EN
  localparam bit c_lzb = 1'b1;
`else
  localparam bit c_lzb = 1'b0;
`endif

  ssd_scan_ctrl #(.SCAN_DIV(8), .GUARD(2), .CNT_W(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .digits(digits),
    .ssd_in(in8), .ssd_ctl(ctl8), .frame_start(fs8)
  );

  ssd_scan_ctrl #(.SCAN_DIV(4), .GUARD(0), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .digits(digits),
    .ssd_in(in4), .ssd_ctl(ctl4), .frame_start(fs4)
  );

  always #5 clk = ~clk;

  // Expected {frame_start, ssd_ctl, ssd_in} for the edge following phase p.
  function automatic logic [8:0] model(int sd, int g, int p, logic [15:0] s);
    int         slot;
    int         idx;
    logic       fs;
    logic [3:0] ctl;
    logic [3:0] code;
    slot = p % sd;
    idx  = (p / sd) % 4;
    fs   = ((p % (4 * sd)) == 0);
    ctl  = 4'hF;
    code = 4'hF;
    if (slot < sd - g) begin
      ctl[idx] = 1'b0;
      code = 4'((s >> (4 * idx)) & 16'hF);
      if (c_lzb && idx > 0 && (s >> (4 * idx)) == 16'h0) code = 4'hF;
    end
    return {fs, ctl, code};
  endfunction

  int          n = 0;
  logic [15:0] s8 = 16'h0, s4 = 16'h0;
  logic [8:0]  e8 = 9'h0FF, e4 = 9'h0FF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n  <= 0;
      e8 <= 9'h0FF;
      e4 <= 9'h0FF;
    end else begin
      if (n % 32 == 0) begin
        s8 <= digits;
        e8 <= model(8, 2, n, digits);
      end else begin
        e8 <= model(8, 2, n, s8);
      end
      if (n % 16 == 0) begin
        s4 <= digits;
        e4 <= model(4, 0, n, digits);
      end else begin
        e4 <= model(4, 0, n, s4);
      end
      n <= n + 1;
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got fs/ctl/in=%b/%b/%h, expected %b/%b/%h at %0t",
               name, act[8], act[7:4], act[3:0], exp[8], exp[7:4], exp[3:0], $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model8", {fs8, ctl8, in8}, e8);
    chk("model4", {fs4, ctl4, in4}, e4);
    checks++;
    if ($countones(~ctl8) > 1) begin
      errors++;
      $display("FAIL onehot8: ctl=%b, required at most one low bit", ctl8);
    end
    if (n >= 1) begin
      checks++;
      if ($countones(~ctl4) != 1) begin
        errors++;
        $display("FAIL noguard4: ctl=%b, required exactly one low bit", ctl4);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [8:0] exp);
    chk(name, {fs8, ctl8, in8}, exp);
  endtask

  initial begin
    // Basic scan with 1234, snapshot change mid-frame.
    step(2);
    lit("reset8", 9'b0_1111_1111);
    chk("reset4", {fs4, ctl4, in4}, 9'b0_1111_1111);
    rst_n = 1'b1;
    step(1); lit("first_fs", 9'b1_1110_0100);
    step(1); lit("fs_drop", 9'b0_1110_0100);
    step(5); lit("guard0", 9'b0_1111_1111);
    step(2); lit("dig1", 9'b0_1101_0011);
    step(8); lit("dig2", 9'b0_1011_0010);
    digits = 16'h5678;
    step(8); lit("dig3_old", 9'b0_0111_0001);
    step(8); lit("new_d0", 9'b1_1110_1000);
    step(8); lit("new_d1", 9'b0_1101_0111);
    step(8); lit("new_d2", 9'b0_1011_0110);
    step(8); lit("new_d3", 9'b0_0111_0101);
    step(40);

    // Asynchronous reset during digit 1 SHOW.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10); lit("pre_rst_d1", 9'b0_1101_0111);
    #2 rst_n = 1'b0;
    #1 lit("async_rst8", 9'b0_1111_1111);
    chk("async_rst4", {fs4, ctl4, in4}, 9'b0_1111_1111);
    step(2);
    digits = 16'h00A0;
    rst_n = 1'b1;
    step(1); lit("restart_d0", 9'b1_1110_0000);
    step(8); lit("code_A", 9'b0_1101_1010);
    step(40);

    // Leading zeros.
    rst_n = 1'b0;
    digits = 16'h0070;
    step(2);
    rst_n = 1'b1;
    step(1); lit("lz_d0", 9'b1_1110_0000);
    step(8); lit("lz_d1", 9'b0_1101_0111);
    step(8); lit("lz_d2", c_lzb ? 9'b0_1011_1111 : 9'b0_1011_0000);
    step(8); lit("lz_d3", c_lzb ? 9'b0_0111_1111 : 9'b0_0111_0000);
    digits = 16'h0000;
    step(8); lit("zero_d0", 9'b1_1110_0000);
    step(8); lit("zero_d1", c_lzb ? 9'b0_1101_1111 : 9'b0_1101_0000);
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
